// File: rtl/spi_xfer_scheduler.sv
// Round-robin scheduler that shares one 3-slave SPI master between three requesters.
// Each grant runs one 8-bit full-duplex transfer and returns the received byte.
module spi_xfer_scheduler #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned BITS       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [23:0] wdata,
  input  logic [5:0]  mode,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [7:0]  spi_din,
  output logic        spi_en,
  output logic [1:0]  spi_slaveno,
  output logic        spi_cpol,
  output logic        spi_cpha,
  output logic        spi_rst,
  input  logic [7:0]  spi_dout
);

  localparam int unsigned CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int unsigned GAP_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t             state;
  logic [1:0]         rr;
  logic [1:0]         win;
  logic [CNT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [1:0]         pick;
  logic [7:0]         pick_byte;
  logic [1:0]         pick_mode;

  // First requester at or after the round-robin pointer, wrapping 2 -> 0.
  always_comb begin
    logic [1:0] cand;
    pick = rr;
    cand = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = 2'((int'(rr) + k) % 3);
      if (req[cand]) pick = cand;
    end
  end

  assign pick_byte = wdata[{pick, 3'b000} +: 8];
  assign pick_mode = mode[{pick, 1'b0} +: 2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr          <= 2'd0;
      win         <= 2'd0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      gnt         <= 3'b000;
      done        <= 3'b000;
      rdata       <= 8'h00;
      busy        <= 1'b0;
      spi_en      <= 1'b0;
      spi_din     <= 8'hFF;
      spi_slaveno <= 2'b11;
      spi_cpol    <= 1'b0;
      spi_cpha    <= 1'b0;
      spi_rst     <= 1'b1;
    end else begin
      done    <= 3'b000;
      spi_rst <= 1'b0;
      case (state)
        IDLE: begin
          spi_en  <= 1'b0;
          spi_din <= 8'hFF;
          if (|req) begin
            state       <= LOAD;
            win         <= pick;
            gnt         <= 3'b001 << pick;
            busy        <= 1'b1;
            spi_slaveno <= pick;
            spi_cpol    <= pick_mode[1];
            spi_cpha    <= pick_mode[0];
            // Master ignores a zero load, so a zero byte is forced via its reset.
            spi_din     <= pick_byte;
            spi_rst     <= (pick_byte == 8'h00);
          end
        end
        LOAD: begin
          state   <= SHIFT;
          spi_en  <= 1'b1;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (bit_cnt == CNT_W'(BITS - 1)) begin
            state   <= CAPTURE;
            spi_en  <= 1'b0;
            spi_din <= 8'h00;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          state   <= GAP;
          rdata   <= spi_dout;
          done    <= 3'b001 << win;
          spi_din <= 8'hFF;
          gap_cnt <= '0;
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            gnt   <= 3'b000;
            busy  <= 1'b0;
            rr    <= (win == 2'd2) ? 2'd0 : win + 2'd1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 3'b000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Directed bench for spi_xfer_scheduler; spi_dout is driven with the byte the
// master would have shifted in for each scenario.
module tb_spi_xfer_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [23:0] wdata = 24'h0;
  logic [5:0]  mode = 6'h0;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic [7:0]  rdata;
  logic        busy;
  logic [7:0]  spi_din;
  logic        spi_en;
  logic [1:0]  spi_slaveno;
  logic        spi_cpol;
  logic        spi_cpha;
  logic        spi_rst;
  logic [7:0]  spi_dout = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  spi_xfer_scheduler #(.GAP_CYCLES(2), .BITS(8)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .mode(mode),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .spi_din(spi_din), .spi_en(spi_en), .spi_slaveno(spi_slaveno),
    .spi_cpol(spi_cpol), .spi_cpha(spi_cpha), .spi_rst(spi_rst),
    .spi_dout(spi_dout)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL reset_gnt: got %b want 000", gnt); end
    n_cmp++; if (done !== 3'b000) begin n_bad++; $display("FAIL reset_done: got %b want 000", done); end
    n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (spi_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", spi_en); end
    n_cmp++; if (spi_din !== 8'hFF) begin n_bad++; $display("FAIL reset_din: got %h want FF", spi_din); end
    n_cmp++; if (spi_slaveno !== 2'b11) begin n_bad++; $display("FAIL reset_slaveno: got %b want 11", spi_slaveno); end
    n_cmp++; if ({spi_cpol, spi_cpha} !== 2'b00) begin n_bad++; $display("FAIL reset_mode: got %b want 00", {spi_cpol, spi_cpha}); end
    n_cmp++; if (spi_rst !== 1'b1) begin n_bad++; $display("FAIL reset_spi_rst: got %b want 1", spi_rst); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (spi_rst !== 1'b0) begin n_bad++; $display("FAIL reset_release_spi_rst: got %b want 0", spi_rst); end
  endtask

  // Single transfer to slave 1 with loopback; checks grant, enable window, done latency.
  task automatic test_single();
    int en_cnt;
    int done_cnt;
    en_cnt = 0;
    done_cnt = 0;
    wdata = 24'h00A500;
    mode = 6'b000000;
    spi_dout = 8'hA5;
    req = 3'b010;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (spi_en === 1'b1) en_cnt++;
      if (done !== 3'b000) done_cnt++;
      if (k == 1) begin
        n_cmp++; if (gnt !== 3'b010) begin n_bad++; $display("FAIL single_gnt: got %b want 010", gnt); end
        n_cmp++; if (spi_slaveno !== 2'd1) begin n_bad++; $display("FAIL single_slaveno: got %0d want 1", spi_slaveno); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
        n_cmp++; if (spi_din !== 8'hA5) begin n_bad++; $display("FAIL single_load_din: got %h want A5", spi_din); end
      end
      if (k >= 2 && k <= 9) begin
        n_cmp++; if (spi_en !== 1'b1) begin n_bad++; $display("FAIL single_en_c%0d: got %b want 1", k, spi_en); end
      end
      if (k == 11) begin
        n_cmp++; if (done !== 3'b010) begin n_bad++; $display("FAIL single_done: got %b want 010", done); end
        n_cmp++; if (rdata !== 8'hA5) begin n_bad++; $display("FAIL single_rdata: got %h want A5", rdata); end
        n_cmp++; if (spi_din !== 8'hFF) begin n_bad++; $display("FAIL single_gap_din: got %h want FF", spi_din); end
        req = 3'b000;
      end
      if (k == 13) begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy: got %b want 0", busy); end
        n_cmp++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL single_idle_gnt: got %b want 000", gnt); end
      end
    end
    n_cmp++; if (en_cnt != 8) begin n_bad++; $display("FAIL single_en_count: got %0d want 8", en_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
  endtask

  // All three requesting from reset: grants rotate 0,1,2,0 every 13 cycles.
  task automatic test_round_robin();
    logic [2:0] exp_done;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wdata = 24'h332211;
    mode = 6'b000000;
    spi_dout = 8'h5A;
    req = 3'b111;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_cmp++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL rr_gnt0: got %b want 001", gnt); end
      end
      if (k == 13) begin
        n_cmp++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL rr_gap_release: got %b want 000", gnt); end
      end
      if (k == 14) begin
        n_cmp++; if (gnt !== 3'b010) begin n_bad++; $display("FAIL rr_gnt1: got %b want 010", gnt); end
      end
      if (k == 27) begin
        n_cmp++; if (gnt !== 3'b100) begin n_bad++; $display("FAIL rr_gnt2: got %b want 100", gnt); end
      end
      if (k == 40) begin
        n_cmp++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL rr_gnt3: got %b want 001", gnt); end
        req = 3'b000;
      end
      exp_done = (k == 11) ? 3'b001 : (k == 24) ? 3'b010 : (k == 37) ? 3'b100 : 3'b000;
      n_cmp++; if (done !== exp_done) begin n_bad++; $display("FAIL rr_done_c%0d: got %b want %b", k, done, exp_done); end
    end
    repeat (14) @(negedge clk);
  endtask

  // Zero byte: master reset pulses in LOAD, data stays 0, miso high returns FF.
  task automatic test_zero_byte();
    wdata = 24'h000000;
    spi_dout = 8'hFF;
    req = 3'b001;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_cmp++; if (spi_rst !== 1'b1) begin n_bad++; $display("FAIL zero_load_rst: got %b want 1", spi_rst); end
        n_cmp++; if (spi_din !== 8'h00) begin n_bad++; $display("FAIL zero_load_din: got %h want 00", spi_din); end
      end
      if (k >= 2 && k <= 9) begin
        n_cmp++; if ({spi_rst, spi_din} !== 9'h000) begin n_bad++; $display("FAIL zero_shift_c%0d: got rst=%b din=%h want 0/00", k, spi_rst, spi_din); end
      end
      if (k == 11) begin
        n_cmp++; if (done !== 3'b001) begin n_bad++; $display("FAIL zero_done: got %b want 001", done); end
        n_cmp++; if (rdata !== 8'hFF) begin n_bad++; $display("FAIL zero_rdata: got %h want FF", rdata); end
        req = 3'b000;
      end
    end
  endtask

  // Slave 2 with cpol=cpha=1 held across SHIFT.
  task automatic test_mode11();
    wdata = 24'h3C0000;
    mode = 6'b110000;
    spi_dout = 8'h3C;
    req = 3'b100;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 2) mode = 6'b000000;
      if (k >= 2 && k <= 9) begin
        n_cmp++; if ({spi_en, spi_cpol, spi_cpha, spi_slaveno} !== 5'b11110) begin n_bad++; $display("FAIL mode_shift_c%0d: got en=%b cpol=%b cpha=%b sl=%0d want 1/1/1/2", k, spi_en, spi_cpol, spi_cpha, spi_slaveno); end
      end
      if (k == 11) begin
        n_cmp++; if (done !== 3'b100) begin n_bad++; $display("FAIL mode_done: got %b want 100", done); end
        n_cmp++; if (rdata !== 8'h3C) begin n_bad++; $display("FAIL mode_rdata: got %h want 3C", rdata); end
        req = 3'b000;
      end
    end
  endtask

  // Reset asserted while SHIFT count is 4: abort without a done pulse.
  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    wdata = 24'h000055;
    spi_dout = 8'h55;
    req = 3'b001;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done !== 3'b000) done_cnt++;
    end
    reset = 1'b1;
    req = 3'b000;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL rmid_gnt: got %b want 000", gnt); end
    n_cmp++; if (spi_rst !== 1'b1) begin n_bad++; $display("FAIL rmid_spi_rst: got %b want 1", spi_rst); end
    n_cmp++; if ({spi_en, spi_din} !== 9'h0FF) begin n_bad++; $display("FAIL rmid_cs_release: got en=%b din=%h want 0/FF", spi_en, spi_din); end
    if (done !== 3'b000) done_cnt++;
    reset = 1'b0;
    for (int k = 8; k <= 16; k++) begin
      @(negedge clk);
      if (done !== 3'b000) done_cnt++;
    end
    n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL rmid_done_count: got %0d want 0", done_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_stay_idle: got %b want 0", busy); end
  endtask

  // req[1] dropped one cycle after grant: transfer still completes, no regrant.
  task automatic test_drop_req();
    int gnt_seen;
    gnt_seen = 0;
    wdata = 24'h00C300;
    mode = 6'b000000;
    spi_dout = 8'hC3;
    req = 3'b010;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) req = 3'b000;
      if (k == 11) begin
        n_cmp++; if (done !== 3'b010) begin n_bad++; $display("FAIL drop_done: got %b want 010", done); end
        n_cmp++; if (rdata !== 8'hC3) begin n_bad++; $display("FAIL drop_rdata: got %h want C3", rdata); end
      end
      if (k == 13) begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy: got %b want 0", busy); end
      end
      if (k >= 13 && gnt !== 3'b000) gnt_seen++;
    end
    n_cmp++; if (gnt_seen != 0) begin n_bad++; $display("FAIL drop_regrant: got %0d grant cycles want 0", gnt_seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_byte();
    test_mode11();
    test_reset_mid();
    test_drop_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
